// File: rtl/cpu_if_pkg.sv
// Shared types and constants for the instruction fetch stage, its decode consumer and monitors.
package cpu_if_pkg;

  localparam int unsigned PC_W  = 32;
  localparam int unsigned INS_W = 32;

  localparam logic [INS_W-1:0] HALT_INS_DEFAULT = 32'h0000000C;

  typedef struct packed {
    logic [PC_W-1:0]  pc;
    logic [INS_W-1:0] ins;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    StFetch,
    StStopped,
    StHalted
  } fetch_state_t;

endpackage

// File: rtl/cpu_if_prefetch_if.sv
// Fetch-stage bundle: redirect input, instruction memory port, decode handshake and debug outputs.
interface cpu_if_prefetch_if
  import cpu_if_pkg::*;
#(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DEPTH  = 4
);
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  logic              redirect_valid;
  logic [PC_W-1:0]   redirect_pc;
  logic [ADDR_W-1:0] imem_addr;
  logic [INS_W-1:0]  imem_data;
  logic              out_valid;
  logic              out_ready;
  logic [PC_W-1:0]   out_pc;
  logic [INS_W-1:0]  out_ins;
  logic [OCC_W-1:0]  occupancy;
  logic [PC_W-1:0]   fetch_pc;
  logic              halt;
  logic [31:0]       cycle_count;

  modport master (
    input  redirect_valid, redirect_pc, imem_data, out_ready,
    output imem_addr, out_valid, out_pc, out_ins, occupancy, fetch_pc, halt, cycle_count
  );

  modport slave (
    output redirect_valid, redirect_pc, imem_data, out_ready,
    input  imem_addr, out_valid, out_pc, out_ins, occupancy, fetch_pc, halt, cycle_count
  );

endinterface

// File: rtl/fetch_fifo.sv
// Prefetch queue of fetch entries; head is read straight from registered storage.
module fetch_fifo
  import cpu_if_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         clr,
  input  logic                         flush,
  input  logic                         enq,
  input  fetch_entry_t                 enq_data,
  input  logic                         deq,
  output fetch_entry_t                 head,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);
  localparam logic [OCC_W-1:0] FULL = OCC_W'(DEPTH);

  fetch_entry_t      mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [OCC_W-1:0]  occ_q;
  logic              do_enq, do_deq;

  // Guards keep the counters sane even if a caller ignores full/empty.
  assign do_deq = deq & (occ_q != '0);
  assign do_enq = enq & ((occ_q != FULL) | do_deq);

  always_ff @(posedge clk) begin
    if (clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (do_enq) begin
        mem_q[wr_ptr_q] <= enq_data;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (do_deq) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (do_enq && !do_deq)      occ_q <= occ_q + OCC_W'(1);
      else if (!do_enq && do_deq) occ_q <= occ_q - OCC_W'(1);
    end
  end

  assign head      = mem_q[rd_ptr_q];
  assign occupancy = occ_q;

endmodule

// File: rtl/cpu_if_prefetch.sv
// Instruction fetch stage: fetch PC, redirect/halt control and cycle counter around a prefetch queue.
module cpu_if_prefetch
  import cpu_if_pkg::*;
#(
  parameter int unsigned      ADDR_W   = 16,
  parameter int unsigned      DEPTH    = 4,
  parameter logic [PC_W-1:0]  RESET_PC = 32'h00000000,
  parameter logic [INS_W-1:0] HALT_INS = HALT_INS_DEFAULT
) (
  input logic               clk,
  input logic               clr,
  cpu_if_prefetch_if.master bus
);
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);
  localparam logic [OCC_W-1:0] FULL = OCC_W'(DEPTH);

  fetch_state_t     state_q;
  logic [PC_W-1:0]  fetch_pc_q;
  logic [31:0]      cycle_q;
  fetch_entry_t     head, enq_data;
  logic [OCC_W-1:0] occ;
  logic             out_valid, deq, enq, flush;

  assign out_valid = (occ != '0) & (state_q != StHalted);
  assign deq       = out_valid & bus.out_ready;
  assign flush     = bus.redirect_valid & (state_q != StHalted);
  // StFetch already excludes both the stopped and halted cases.
  assign enq       = ~bus.redirect_valid & (state_q == StFetch) & ((occ != FULL) | deq);
  assign enq_data  = '{pc: fetch_pc_q, ins: bus.imem_data};

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .clr       (clr),
    .flush     (flush),
    .enq       (enq),
    .enq_data  (enq_data),
    .deq       (deq),
    .head      (head),
    .occupancy (occ)
  );

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q    <= StFetch;
      fetch_pc_q <= RESET_PC;
      cycle_q    <= 32'd1;
    end else begin
      if (flush)    fetch_pc_q <= bus.redirect_pc;
      else if (enq) fetch_pc_q <= fetch_pc_q + 32'd1;

      // Consuming the halt word outranks any redirect or fetch in the same cycle.
      if (deq && head.ins == HALT_INS) begin
        state_q <= StHalted;
      end else begin
        unique case (state_q)
          StFetch:   if (enq && bus.imem_data == HALT_INS) state_q <= StStopped;
          StStopped: if (flush) state_q <= StFetch;
          default:   state_q <= state_q;
        endcase
      end

      if (state_q != StHalted && cycle_q != 32'hFFFFFFFF) cycle_q <= cycle_q + 32'd1;
    end
  end

  assign bus.imem_addr   = fetch_pc_q[ADDR_W-1:0];
  assign bus.out_valid   = out_valid;
  assign bus.out_pc      = head.pc;
  assign bus.out_ins     = head.ins;
  assign bus.occupancy   = occ;
  assign bus.fetch_pc    = fetch_pc_q;
  assign bus.halt        = (state_q == StHalted);
  assign bus.cycle_count = cycle_q;

endmodule

// File: doc/cpu_if_prefetch.md
Name: cpu_if_prefetch

Overview:
Parametrised next-generation instruction fetch stage with a prefetch queue.
- Fetches one word-addressed instruction per cycle from a combinational instruction memory into a DEPTH-entry FIFO.
- Presents {pc, ins} to decode over a valid/ready handshake.
- Accepts branch/jump redirects from EX, which flush the queue.
- Detects a halt instruction and keeps a cycle counter that freezes on halt.

Parameters:
ADDR_W, 16, instruction memory address width (imem_addr = fetch_pc[ADDR_W-1:0])
DEPTH, 4, prefetch FIFO entries; power of two, >= 2
RESET_PC, 32'h00000000, fetch PC loaded on reset
HALT_INS, 32'h0000000C, instruction encoding that terminates fetch

Ports:
clk  in  1  clock
clr  in  1  reset; one clock, reset is synchronous and active-high
redirect_valid  in  1  EX requests a PC change this cycle
redirect_pc  in  32  target PC for redirect
imem_addr  out  ADDR_W  instruction memory address (combinational from fetch_pc)
imem_data  in  32  instruction memory read data, same cycle
out_valid  out  1  head entry valid
out_ready  in  1  decode accepts head
out_pc  out  32  PC of head entry
out_ins  out  32  instruction of head entry
occupancy  out  $clog2(DEPTH+1)  entries queued
fetch_pc  out  32  next PC to fetch (debug)
halt  out  1  sticky; HALT_INS has been consumed by decode
cycle_count  out  32  cycles since reset, frozen after halt

Behaviour:
- Reset (clr=1 at posedge), overriding all other inputs:
  - fetch_pc=RESET_PC, occupancy=0, out_valid=0, out_pc=0, out_ins=0.
  - halt=0, fetch_stopped=0, cycle_count=1.
  - Reset mid-operation discards all queued entries.
- deq = out_valid & out_ready & ~halt.
- enq = ~redirect_valid & ~fetch_stopped & ~halt & (occupancy<DEPTH | deq).
  - Enqueue while full is legal only when a dequeue happens in the same cycle.
- On enq:
  - Write {fetch_pc, imem_data} at the tail.
  - fetch_pc <= fetch_pc+1; 32-bit wrap, 32'hFFFFFFFF -> 0.
  - If imem_data==HALT_INS, set fetch_stopped=1. The HALT word itself is enqueued.
- Latency: a word fetched in cycle N is visible at out_valid/out_pc/out_ins in cycle N+1 if the queue was empty.
- out_* are driven from registered FIFO storage (head pointer). out_valid = (occupancy!=0) & ~halt.
- Occupancy:
  - +1 on enq only; -1 on deq only; unchanged on both or neither.
  - Never exceeds DEPTH and never underflows.
- Redirect (redirect_valid=1, halt=0):
  - Same cycle: flush the FIFO (occupancy=0, pointers=0), fetch_pc <= redirect_pc, fetch_stopped <= 0.
  - No enqueue that cycle. A concurrent deq still counts as accepted, since decode sampled the head; the flush then applies.
  - First redirected entry reaches out_valid 2 cycles after redirect_valid.
- Halt:
  - halt <= 1 on the cycle after a deq whose out_ins==HALT_INS.
  - Once halt=1: no enq, no deq, out_valid=0, redirects ignored, cycle_count frozen. Only clr clears it.
- cycle_count: +1 per cycle while halt=0; saturates at 32'hFFFFFFFF.
- Pointers are $clog2(DEPTH) bits, wrap naturally. Occupancy is tracked separately to distinguish full from empty.

Decomposition:
- Package cpu_if_pkg:
  - typedef fetch_entry_t (packed struct: logic [31:0] pc; logic [31:0] ins).
  - Localparams PC_W=32, INS_W=32.
  - Default HALT_INS encoding, shared with decode and the monitor.
- Sub-module fetch_fifo: synchronous FIFO of fetch_entry_t.
  - Parameter DEPTH.
  - Ports enq/deq/flush, head, occupancy.
  - flush takes priority over enq.
- The top level holds fetch_pc, the enq/deq/redirect/halt control and cycle_count.

Test Plan:
- Reset, RESET_PC=0, memory words 0..7 = 0x100..0x107, out_ready=1:
  - out_valid rises 1 cycle after reset release.
  - out_pc sequence 0,1,2,...; out_ins sequence 0x100, 0x101, ...
  - cycle_count = 1 at first post-reset cycle, then increments by 1 per cycle.
- out_ready=0 for 10 cycles, DEPTH=4:
  - occupancy reaches 4 and holds; fetch_pc stays 4.
  - Raise out_ready: entries pc 0..3 drain in order, and refill continues with no bubble.
- Full queue with out_ready=1 steady: enq+deq every cycle, occupancy constant at 4, no entry lost or duplicated.
- Queue holding pc 5..8, redirect_valid=1 with redirect_pc=0x20:
  - Next cycle occupancy=0 and fetch_pc=0x20.
  - Following cycle out_pc=0x20.
  - No pc 5..8 entry is ever presented after the redirect cycle.
- Memory word 3 = HALT_INS:
  - Fetch stops after pc 3 (fetch_pc holds 4).
  - halt=1 the cycle after pc 3 is dequeued.
  - cycle_count frozen from then on; a later redirect_valid has no effect.
- clr asserted with 3 queued entries and halt=1:
  - Next cycle occupancy=0, out_valid=0, halt=0, fetch_pc=RESET_PC, cycle_count=1.
